// File: rtl/cpu_alu_seq.sv
// Multi-cycle ALU with its own {I,C,Z,V,N} flag register. Shifts and MUL iterate
// one bit per EXEC cycle; every state change happens on the falling clock edge.
module cpu_alu_seq #(
    parameter int WIDTH  = 16,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       flags,
    output logic             wr_en,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_CMP  = 4'b0000, OP_SEXT = 4'b0001, OP_SETS = 4'b0010,
                           OP_GETS = 4'b0011, OP_ADDC = 4'b0100, OP_SUBC = 4'b0101,
                           OP_TST  = 4'b0110, OP_MUL  = 4'b0111, OP_ADD  = 4'b1000,
                           OP_SUB  = 4'b1001, OP_SHL  = 4'b1010, OP_SHR  = 4'b1011,
                           OP_AND  = 4'b1100, OP_OR   = 4'b1101, OP_INV  = 4'b1110,
                           OP_XOR  = 4'b1111;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [3:0]           op_q;
    logic [WIDTH-1:0]     a_q, b_q, result_q, result_d;
    logic [2*WIDTH-1:0]   w_q, w_d;
    logic                 c_q, c_d, bz_q, wr_en_q, wr_d;
    logic [CW-1:0]        cnt_q, n_acc;
    logic [4:0]           flags_q, flags_d;

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_EXEC;
            S_EXEC:  if (cnt_q == '0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
    end

    // Iteration count: shifts clamp to WIDTH and never drop below one cycle.
    always_comb begin
        n_acc = CW'(1);
        if (op == OP_SHL || op == OP_SHR) begin
            if (b >= WIDTH'(WIDTH)) n_acc = CW'(WIDTH);
            else if (b != '0)       n_acc = b[CW-1:0];
        end else if (op == OP_MUL && MUL_EN) begin
            n_acc = CW'(WIDTH);
        end
    end

    // One iteration step: MUL shifts the product right, shifts move one bit.
    logic [WIDTH:0] mul_sum;
    always_comb begin
        w_d     = w_q;
        c_d     = c_q;
        mul_sum = {1'b0, w_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q};
        if (op_q == OP_MUL) begin
            w_d = w_q[0] ? {mul_sum, w_q[WIDTH-1:1]} : {1'b0, w_q[2*WIDTH-1:1]};
        end else if (op_q == OP_SHL && !bz_q) begin
            c_d = w_q[WIDTH-1];
            w_d = {w_q[2*WIDTH-1:WIDTH], w_q[WIDTH-2:0], 1'b0};
        end else if (op_q == OP_SHR && !bz_q) begin
            c_d = w_q[0];
            w_d = {w_q[2*WIDTH-1:WIDTH], 1'b0, w_q[WIDTH-1:1]};
        end
    end

    logic             cin, c_fin, v_fin, keep_res, keep_flg;
    logic [WIDTH:0]   add_s, sub_s;
    logic [WIDTH-1:0] r_fin;
    always_comb begin
        cin      = (op_q == OP_ADDC || op_q == OP_SUBC) ? flags_q[3] : 1'b0;
        add_s    = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin};
        sub_s    = {1'b0, a_q} - {1'b0, b_q} - {{WIDTH{1'b0}}, cin};
        r_fin    = '0;
        c_fin    = 1'b0;
        v_fin    = 1'b0;
        wr_d     = 1'b1;
        keep_res = 1'b0;
        keep_flg = 1'b0;
        case (op_q)
            OP_CMP, OP_SUB, OP_SUBC: begin
                r_fin = sub_s[WIDTH-1:0];
                c_fin = sub_s[WIDTH];
                v_fin = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ sub_s[WIDTH-1]);
                wr_d  = (op_q != OP_CMP);
            end
            OP_ADD, OP_ADDC: begin
                r_fin = add_s[WIDTH-1:0];
                c_fin = add_s[WIDTH];
                v_fin = (a_q[WIDTH-1] ~^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ add_s[WIDTH-1]);
            end
            OP_SEXT: r_fin = {{(WIDTH-8){a_q[7]}}, a_q[7:0]};
            OP_SETS: begin
                wr_d     = 1'b0;
                keep_res = 1'b1;
            end
            OP_GETS: begin
                r_fin    = {{(WIDTH-5){1'b0}}, flags_q};
                keep_flg = 1'b1;
            end
            OP_TST: begin
                r_fin = a_q & b_q;
                wr_d  = 1'b0;
            end
            OP_MUL: begin
                if (MUL_EN) begin
                    r_fin = w_q[WIDTH-1:0];
                    c_fin = |w_q[2*WIDTH-1:WIDTH];
                end else begin
                    wr_d     = 1'b0;
                    keep_res = 1'b1;
                    keep_flg = 1'b1;
                end
            end
            OP_SHL, OP_SHR: begin
                r_fin = w_q[WIDTH-1:0];
                c_fin = c_q;
            end
            OP_AND:  r_fin = a_q & b_q;
            OP_OR:   r_fin = a_q | b_q;
            OP_INV:  r_fin = ~a_q;
            OP_XOR:  r_fin = a_q ^ b_q;
            default: r_fin = '0;
        endcase
        result_d = keep_res ? result_q : r_fin;
        if (op_q == OP_SETS) flags_d = a_q[4:0];
        else if (keep_flg)   flags_d = flags_q;
        else                 flags_d = {flags_q[4], c_fin, (r_fin == '0), v_fin, r_fin[WIDTH-1]};
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            w_q      <= '0;
            c_q      <= 1'b0;
            bz_q     <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
            wr_en_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    op_q  <= op;
                    a_q   <= a;
                    b_q   <= b;
                    cnt_q <= n_acc;
                    bz_q  <= (b == '0);
                    c_q   <= 1'b0;
                    w_q   <= (op == OP_MUL) ? {{WIDTH{1'b0}}, b} : {{WIDTH{1'b0}}, a};
                end
                S_EXEC: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                        w_q   <= w_d;
                        c_q   <= c_d;
                    end else begin
                        result_q <= result_d;
                        flags_q  <= flags_d;
                        wr_en_q  <= wr_d;
                    end
                end
                S_DONE:  wr_en_q <= 1'b0;
                default: wr_en_q <= 1'b0;
            endcase
        end
    end

    assign result = result_q;
    assign flags  = flags_q;
    assign wr_en  = wr_en_q;

endmodule

// File: tb/tb_cpu_alu_seq.sv
// Bench for cpu_alu_seq: directed plan items, randomized ops against an arithmetic
// reference model, a MUL_EN=0 instance, and an asynchronous abort mid-MUL.
module tb_cpu_alu_seq;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, start0 = 1'b0;
    logic [3:0]  op = '0;
    logic [15:0] a = '0, b = '0;
    logic [15:0] result, result0;
    logic [4:0]  flags, flags0;
    logic        wr_en, wr_en0, busy, busy0, done, done0;

    int npass = 0, ntot = 0, nfail = 0;
    logic [4:0] mflags = '0, mflags0 = '0;

    always #5 clk = ~clk;

    cpu_alu_seq #(.WIDTH(16), .MUL_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .result(result), .flags(flags), .wr_en(wr_en), .busy(busy), .done(done));

    cpu_alu_seq #(.WIDTH(16), .MUL_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .op(op), .a(a), .b(b),
        .result(result0), .flags(flags0), .wr_en(wr_en0), .busy(busy0), .done(done0));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic from the operation definitions.
    task automatic model(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                         input bit mul_en, inout logic [4:0] fl,
                         output logic [15:0] r, output logic ew, output int lat, output bit chkr);
        int unsigned A = x, B = y, ci, p, bb;
        bit c = 0, v = 0, keep = 0;
        ci = 0; r = '0; ew = 1'b1; chkr = 1'b1; lat = 2;
        bb = (B > 16) ? 16 : B;
        case (o)
            4'h0, 4'h9, 4'h5: begin
                if (o == 4'h5) ci = fl[3];
                r = 16'((A - B - ci) & 32'hFFFF);
                c = (A < B + ci);
                v = ((((A ^ B) & (A ^ r)) >> 15) & 1) != 0;
                if (o == 4'h0) begin ew = 0; chkr = 0; end
            end
            4'h4, 4'h8: begin
                if (o == 4'h4) ci = fl[3];
                p = A + B + ci;
                r = 16'(p & 32'hFFFF);
                c = (p > 32'hFFFF);
                v = ((((A ^ ~B) & (A ^ r)) >> 15) & 1) != 0;
            end
            4'h1: r = x[7] ? {8'hFF, x[7:0]} : {8'h00, x[7:0]};
            4'h2: begin fl = x[4:0]; ew = 0; chkr = 0; keep = 1; end
            4'h3: begin r = {11'b0, fl}; keep = 1; end
            4'h6: begin r = x & y; ew = 0; chkr = 0; end
            4'h7: begin
                if (mul_en) begin
                    p = A * B;
                    r = 16'(p & 32'hFFFF);
                    c = (p > 32'hFFFF);
                    lat = 17;
                end else begin
                    ew = 0; chkr = 0; keep = 1;
                end
            end
            4'hA, 4'hB: begin
                if (bb == 0) r = x;
                else if (o == 4'hA) begin
                    r = 16'((A << bb) & 32'hFFFF);
                    c = ((A >> (16 - bb)) & 1) != 0;
                end else begin
                    r = 16'(A >> bb);
                    c = ((A >> (bb - 1)) & 1) != 0;
                end
                lat = ((bb == 0) ? 1 : int'(bb)) + 1;
            end
            4'hC: r = x & y;
            4'hD: r = x | y;
            4'hE: r = ~x;
            default: r = x ^ y;
        endcase
        if (!keep) fl = {fl[4], c, (r == 16'h0), v, r[15]};
    endtask

    // Issue one op and count falling edges from acceptance until done is seen.
    task automatic issue(input bit sel, input logic [3:0] o, input logic [15:0] x,
                         input logic [15:0] y, output int lat);
        @(posedge clk);
        op = o; a = x; b = y;
        if (sel) start0 = 1'b1; else start = 1'b1;
        @(negedge clk);
        @(posedge clk);
        start = 1'b0; start0 = 1'b0;
        lat = -1;
        for (int e = 1; e <= 40; e++) begin
            @(negedge clk);
            @(posedge clk);
            if ((sel ? done0 : done) === 1'b1) begin lat = e; break; end
        end
    endtask

    task automatic do_op(input bit sel, input logic [3:0] o, input logic [15:0] x,
                         input logic [15:0] y, input string tag);
        int lat, elat;
        logic [15:0] er;
        logic ew;
        bit chkr;
        issue(sel, o, x, y, lat);
        if (sel) model(o, x, y, 1'b0, mflags0, er, ew, elat, chkr);
        else     model(o, x, y, 1'b1, mflags, er, ew, elat, chkr);
        chk({tag, " latency"}, lat, elat);
        if (chkr) chk({tag, " result"}, sel ? result0 : result, er);
        chk({tag, " flags"}, sel ? flags0 : flags, sel ? mflags0 : mflags);
        chk({tag, " wr_en"}, sel ? wr_en0 : wr_en, ew);
    endtask

    initial begin
        int dcount;
        logic [3:0]  ro;
        logic [15:0] rx, ry;

        #1 rst = 1'b0;
        #2;
        chk("reset result", result, 16'h0);
        chk("reset flags", flags, 5'h0);
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset wr_en", wr_en, 1'b0);
        @(posedge clk) rst = 1'b1;

        do_op(0, 4'h8, 16'h7FFF, 16'h0001, "add ovf");
        chk("add ovf const", {result, flags}, {16'h8000, 5'b00011});
        do_op(0, 4'h2, 16'h0008, 16'h0000, "sets");
        chk("sets const", flags, 5'b01000);
        do_op(0, 4'h5, 16'h0000, 16'h0000, "subc");
        chk("subc const", {result, flags}, {16'hFFFF, 5'b01001});
        do_op(0, 4'hA, 16'h8001, 16'h0004, "shl4");
        chk("shl4 const", {result, flags[3]}, {16'h0010, 1'b0});
        do_op(0, 4'hB, 16'h0003, 16'h0001, "shr1");
        chk("shr1 const", {result, flags[3]}, {16'h0001, 1'b1});
        do_op(0, 4'hA, 16'h8001, 16'd20, "shl20");
        chk("shl20 const", {result, flags[2]}, {16'h0000, 1'b1});
        do_op(0, 4'hA, 16'h1234, 16'h0000, "shl0");
        do_op(0, 4'h7, 16'h0100, 16'h0101, "mul");
        chk("mul const", {result, flags[3]}, {16'h0100, 1'b1});
        do_op(0, 4'h3, 16'h0000, 16'h0000, "gets");
        do_op(0, 4'h1, 16'h0080, 16'h0000, "sext");

        // CMP with start held high while busy: only one completion.
        @(posedge clk);
        op = 4'h0; a = 16'h0005; b = 16'h0005; start = 1'b1;
        @(negedge clk);
        dcount = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            if (done === 1'b1) dcount++;
            if (i == 2) start = 1'b0;
        end
        chk("cmp one done", dcount, 1);
        chk("cmp flags", flags, {mflags[4], 4'b0100});
        chk("cmp wr_en idle", wr_en, 1'b0);
        mflags = {mflags[4], 4'b0100};

        do_op(1, 4'h2, 16'h001A, 16'h0000, "nomul sets");
        do_op(1, 4'h7, 16'h0003, 16'h0005, "nomul mul");
        chk("nomul flags const", flags0, 5'b11010);

        for (int i = 0; i < 40; i++) begin
            ro = 4'($urandom_range(0, 15));
            rx = 16'($urandom);
            ry = (ro == 4'hA || ro == 4'hB) ? 16'($urandom_range(0, 20)) : 16'($urandom);
            do_op(0, ro, rx, ry, $sformatf("rnd%0d op%0h", i, ro));
        end

        // Abort a MUL after eight EXEC cycles.
        @(posedge clk);
        op = 4'h7; a = 16'h1234; b = 16'h5678; start = 1'b1;
        @(negedge clk);
        @(posedge clk) start = 1'b0;
        repeat (8) @(negedge clk);
        @(posedge clk) rst = 1'b0;
        #1;
        chk("abort busy", busy, 1'b0);
        chk("abort done", done, 1'b0);
        chk("abort result", result, 16'h0);
        chk("abort flags", flags, 5'h0);
        @(posedge clk) rst = 1'b1;
        mflags = '0;
        mflags0 = '0;
        do_op(0, 4'h8, 16'h0001, 16'h0002, "post-abort add");

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/cpu_alu_seq.md
Name: cpu_alu_seq

Overview:
- Parametrised, multi-cycle ALU with its own ICZVN flag register, for the next-generation microcpu core.
- Replaces the core's fixed 16-bit inline ALU. Adds configurable width, iterative shifts, unsigned multiply and an explicit start/busy/done handshake.
- Sits beside the register file. The core issues one operation, stalls on busy, and writes result back when wr_en is high.

Parameters:
- WIDTH, 16, operand/result width in bits; minimum 8.
- MUL_EN, 1, 1 = op 0111 is MUL; 0 = op 0111 completes as a NOP (no flag change, wr_en=0).

Ports:
- clk  in  1  clock; all state changes on the falling edge, as in the core.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  issue request; sampled only in IDLE.
- op  in  4  operation code, latched on accept.
- a  in  WIDTH  operand 1, latched on accept.
- b  in  WIDTH  operand 2 or shift count, latched on accept.
- result  out  WIDTH  registered result; valid when done=1, held until the next done.
- flags  out  5  {I,C,Z,V,N}, registered, always valid (read by the branch logic).
- wr_en  out  1  result must be written to the destination register; qualified by done.
- busy  out  1  high in EXEC and DONE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; result=0, flags=0, wr_en=0, busy=0, done=0; internal counters cleared.
  - Reset mid-operation aborts it; no write, no flag update.
- FSM: IDLE -> EXEC -> DONE -> IDLE.
  - IDLE: on start=1, latch op/a/b and the iteration count n; go to EXEC.
  - EXEC: runs n cycles (below), then goes to DONE.
  - DONE: one cycle with done=1; result/flags/wr_en updated on entry; then IDLE.
- start while busy=1 is ignored; it is not queued.
- Latency: done is high in the cycle after falling edge k+n+1, where k is the accept edge.
  - n=1 for single-step ops.
  - Shifts: n = max(1, min(b, WIDTH)).
  - MUL: n = WIDTH.
- Ops (C_in is flag C at accept):
  - 0000 CMP: a-b; flags only.
  - 0001 SEXT: sign-extend a[7:0].
  - 0010 SETS: {I,C,Z,V,N} <= a[4:0]; no write.
  - 0011 GETS: result = zero-extended flags; flags unchanged.
  - 0100 ADDC: a+b+C_in.
  - 0101 SUBC: a-b-C_in.
  - 0110 TST: a&b; flags only.
  - 0111 MUL: unsigned shift-add, low WIDTH bits.
  - 1000 ADD: a+b.
  - 1001 SUB: a-b.
  - 1010 SHL: a<<b, one bit per EXEC cycle.
  - 1011 SHR: a>>b (logical), one bit per EXEC cycle.
  - 1100 AND.
  - 1101 OR.
  - 1110 INV: ~a.
  - 1111 XOR.
- Arithmetic uses a WIDTH+1 accumulator.
- Flags for every op except SETS/GETS:
  - Z = (result==0); N = result[WIDTH-1].
  - C: carry out for add; borrow for sub/CMP.
  - C for shifts: last bit shifted out; b=0 gives C=0; b>=WIDTH gives result 0 and C = last bit out.
  - C for MUL: 1 if the upper WIDTH product bits are nonzero.
  - C=0 for logic, INV and SEXT.
  - V for add: (a^~b)&(a^r) at the MSB.
  - V for sub/CMP: (a^b)&(a^r) at the MSB.
  - V=0 otherwise.
- I changes only via SETS.
- wr_en=1 in DONE, except for CMP, TST, SETS and a disabled MUL.

Test Plan:
- WIDTH=16, ADD a=7FFF b=0001 -> done 2 edges after accept, result=8000, flags N=1 V=1 C=0 Z=0, wr_en=1.
- SETS a=0008 -> flags=01000, wr_en=0; then SUBC a=0000 b=0000 -> result=FFFF, C=1 N=1 Z=0 V=0.
- SHL a=8001 b=4 -> result=0010, C=0, done 5 edges after accept; SHR a=0003 b=1 -> result=0001, C=1; SHL b=20 -> result=0000, Z=1.
- MUL a=0100 b=0101 -> result=0100, C=1, done 17 edges after accept; with MUL_EN=0, flags unchanged and wr_en=0.
- CMP a=0005 b=0005 -> Z=1 C=0, wr_en=0; a second start pulse during busy is ignored (exactly one done pulse).
- Drive rst low during MUL cycle 8 -> immediately busy=0, done=0, result=0000, flags=00000; first op after release completes normally.
